// File: rtl/coe_load_controller_if.sv
// Byte-receiver and memory-write-port bundle of the UART program loader.
// The controller takes the slave view; the byte source / memory side takes master.
interface coe_load_controller_if #(
    parameter int unsigned ADDR_WIDTH = 14
) ();
    logic                  iStartReceiveCoe;
    logic                  iRxValid;
    logic [7:0]            iRxData;
    logic                  oCpuHold;
    logic                  oMemWe;
    logic                  oMemSel;
    logic [ADDR_WIDTH-1:0] oMemAddr;
    logic [31:0]           oMemWdata;
    logic                  oLoadBusy;
    logic                  oLoadDone;
    logic                  oLoadErr;

    modport master (
        output iStartReceiveCoe, iRxValid, iRxData,
        input  oCpuHold, oMemWe, oMemSel, oMemAddr, oMemWdata,
               oLoadBusy, oLoadDone, oLoadErr
    );

    modport slave (
        input  iStartReceiveCoe, iRxValid, iRxData,
        output oCpuHold, oMemWe, oMemSel, oMemAddr, oMemWdata,
               oLoadBusy, oLoadDone, oLoadErr
    );
endinterface

// File: rtl/coe_load_controller.sv
// UART program loader: holds the CPU in reset, packs received bytes big-endian
// into words and writes them to instruction memory, then data memory.
module coe_load_controller #(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned IMEM_WORDS     = 16384,
    parameter int unsigned DMEM_WORDS     = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
    input  logic                   iFpgaClk,
    input  logic                   iFpgaRst,
    coe_load_controller_if.slave   bus
);

    localparam int unsigned WCW         = ADDR_WIDTH + 1;
    localparam int unsigned TOTAL_WORDS = IMEM_WORDS + DMEM_WORDS;
    localparam int unsigned TOW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e                state_q,      state_d;
    logic                  start_q,      start_prev_q;
    logic [1:0]            byte_cnt_q,   byte_cnt_d;
    logic [WCW-1:0]        word_cnt_q,   word_cnt_d;
    logic [23:0]           shift_q,      shift_d;
    logic [TOW-1:0]        to_cnt_q,     to_cnt_d;
    logic                  armed_q,      armed_d;
    logic                  hold_q,       hold_d;
    logic                  busy_q,       busy_d;
    logic                  we_q,         we_d;
    logic                  sel_q,        sel_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [31:0]           wdata_q,      wdata_d;
    logic                  done_q,       done_d;
    logic                  err_q,        err_d;

    logic start_edge_c;
    logic byte_ok_c;

    assign start_edge_c = start_q & ~start_prev_q;
    // Bytes beyond the final word are dropped.
    assign byte_ok_c    = bus.iRxValid && (word_cnt_q < WCW'(TOTAL_WORDS));

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        to_cnt_d   = to_cnt_q;
        armed_d    = armed_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        we_d       = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge_c) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                    to_cnt_d   = '0;
                    armed_d    = 1'b0;
                    err_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (we_q && (word_cnt_q == WCW'(TOTAL_WORDS))) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else if (byte_ok_c) begin
                    shift_d    = {shift_q[15:0], bus.iRxData};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    to_cnt_d   = '0;
                    armed_d    = 1'b1;
                    // Fourth byte: the write goes out next cycle, so the shifter is free again.
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {shift_q, bus.iRxData};
                        word_cnt_d = word_cnt_q + WCW'(1);
                        if (word_cnt_q < WCW'(IMEM_WORDS)) begin
                            sel_d  = 1'b0;
                            addr_d = ADDR_WIDTH'(word_cnt_q);
                        end else begin
                            sel_d  = 1'b1;
                            addr_d = ADDR_WIDTH'(word_cnt_q - WCW'(IMEM_WORDS));
                        end
                    end
                end else if (armed_q) begin
                    if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        err_d   = (byte_cnt_q != 2'd0);
                    end else begin
                        to_cnt_d = to_cnt_q + TOW'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        hold_d = (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iFpgaClk or negedge iFpgaRst) begin
        if (!iFpgaRst) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            to_cnt_q     <= '0;
            armed_q      <= 1'b0;
            hold_q       <= 1'b0;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= bus.iStartReceiveCoe;
            start_prev_q <= start_q;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            to_cnt_q     <= to_cnt_d;
            armed_q      <= armed_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.oCpuHold  = hold_q;
    assign bus.oMemWe    = we_q;
    assign bus.oMemSel   = sel_q;
    assign bus.oMemAddr  = addr_q;
    assign bus.oMemWdata = wdata_q;
    assign bus.oLoadBusy = busy_q;
    assign bus.oLoadDone = done_q;
    assign bus.oLoadErr  = err_q;

endmodule

// File: tb/tb_coe_load_controller.sv
// Directed bench for coe_load_controller with small memories (2+2 words) and a 100-cycle timeout.
module tb_coe_load_controller;

    logic clk;
    logic rst_n;

    coe_load_controller_if #(.ADDR_WIDTH(14)) bus ();

    coe_load_controller #(
        .ADDR_WIDTH    (14),
        .IMEM_WORDS    (2),
        .DMEM_WORDS    (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .iFpgaClk(clk),
        .iFpgaRst(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [46:0] wr_q[$];
    int done_cnt  = 0;
    int hold_viol = 0;

    // Record writes {sel, addr, data} and done pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n && bus.oMemWe) wr_q.push_back({bus.oMemSel, bus.oMemAddr, bus.oMemWdata});
        if (rst_n && bus.oLoadDone) done_cnt++;
        if (bus.oMemWe && !bus.oCpuHold) hold_viol++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.iRxValid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.iRxValid = 1'b1;
        bus.iRxData  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_byte(b);
        idle(2);
    endtask

    task automatic press();
        bus.iStartReceiveCoe = 1'b1;
        idle(3);
        bus.iStartReceiveCoe = 1'b0;
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n                = 1'b0;
        bus.iStartReceiveCoe = 1'b0;
        bus.iRxValid         = 1'b0;
        bus.iRxData          = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold",  64'(bus.oCpuHold),  64'd0);
        check("rst_we",    64'(bus.oMemWe),    64'd0);
        check("rst_busy",  64'(bus.oLoadBusy), 64'd0);
        check("rst_done",  64'(bus.oLoadDone), 64'd0);
        check("rst_err",   64'(bus.oLoadErr),  64'd0);
        check("rst_addr",  64'(bus.oMemAddr),  64'd0);
        check("rst_wdata", 64'(bus.oMemWdata), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Bytes in IDLE are ignored.
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        check("idle_no_write", 64'(wr_q.size()), 64'd0);

        // Button held high for 50 cycles: one load only.
        bus.iStartReceiveCoe = 1'b1;
        idle(50);
        check("held_hold", 64'(bus.oCpuHold),  64'd1);
        check("held_busy", 64'(bus.oLoadBusy), 64'd1);
        bus.iStartReceiveCoe = 1'b0;
        idle(2);

        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("w0_count", 64'(wr_q.size()), 64'd1);
        check("w0_entry", 64'(wr_q[0]), 64'({1'b0, 14'd0, 32'h12345678}));
        check("w0_hold",  64'(bus.oCpuHold), 64'd1);

        // Second press during LOAD must not restart the counters.
        press();
        check("repress_hold", 64'(bus.oCpuHold), 64'd1);

        // Back-to-back bytes, including one in each write cycle, plus one extra.
        drive_byte(8'hA1); drive_byte(8'hB2); drive_byte(8'hC3); drive_byte(8'hD4);
        drive_byte(8'hDE); drive_byte(8'hAD); drive_byte(8'hBE); drive_byte(8'hEF);
        drive_byte(8'hCA); drive_byte(8'hFE); drive_byte(8'hF0); drive_byte(8'h0D);
        check("last_we", 64'(bus.oMemWe), 64'd1);
        drive_byte(8'hFF);
        bus.iRxValid = 1'b0;
        check("fin_done", 64'(bus.oLoadDone), 64'd1);
        check("fin_hold", 64'(bus.oCpuHold),  64'd1);
        check("fin_err",  64'(bus.oLoadErr),  64'd0);
        idle(1);
        check("rel_hold", 64'(bus.oCpuHold),  64'd0);
        check("rel_busy", 64'(bus.oLoadBusy), 64'd0);
        check("rel_done", 64'(bus.oLoadDone), 64'd0);
        check("full_count", 64'(wr_q.size()), 64'd4);
        check("w1_entry", 64'(wr_q[1]), 64'({1'b0, 14'd1, 32'hA1B2C3D4}));
        check("w2_entry", 64'(wr_q[2]), 64'({1'b1, 14'd0, 32'hDEADBEEF}));
        check("w3_entry", 64'(wr_q[3]), 64'({1'b1, 14'd1, 32'hCAFEF00D}));
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("post_no_write", 64'(wr_q.size()), 64'd4);
        check("done_once",     64'(done_cnt),    64'd1);

        // Timeout with a partial word pending.
        wr_q.delete();
        press();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        drive_byte(8'h06);
        bus.iRxValid = 1'b0;
        n = 0;
        while (!bus.oLoadDone && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("to_latency", 64'(n), 64'd100);
        check("to_done",    64'(bus.oLoadDone), 64'd1);
        check("to_err",     64'(bus.oLoadErr),  64'd1);
        check("to_count",   64'(wr_q.size()),   64'd1);
        check("to_entry",   64'(wr_q[0]), 64'({1'b0, 14'd0, 32'h01020304}));
        idle(1);
        check("to_release", 64'(bus.oCpuHold), 64'd0);
        check("to_err_sticky", 64'(bus.oLoadErr), 64'd1);
        press();
        check("err_cleared", 64'(bus.oLoadErr), 64'd0);

        // No byte yet: timeout is not armed, CPU stays held.
        idle(150);
        check("unarmed_hold", 64'(bus.oCpuHold), 64'd1);
        check("unarmed_done_cnt", 64'(done_cnt), 64'd2);

        // Asynchronous reset in the middle of a write cycle.
        drive_byte(8'h0B); drive_byte(8'hAD); drive_byte(8'hF0); drive_byte(8'h0D);
        bus.iRxValid = 1'b0;
        check("pre_rst_we", 64'(bus.oMemWe), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we",   64'(bus.oMemWe),    64'd0);
        check("arst_hold", 64'(bus.oCpuHold),  64'd0);
        check("arst_busy", 64'(bus.oLoadBusy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("post_rst_hold", 64'(bus.oCpuHold), 64'd0);
        wr_q.delete();
        press();
        send_byte(8'h89); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
        check("restart_count", 64'(wr_q.size()), 64'd1);
        check("restart_entry", 64'(wr_q[0]), 64'({1'b0, 14'd0, 32'h89ABCDEF}));
        check("hold_never_we", 64'(hold_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
